mult_vec_engine: RTL and testbench
==================================

MULT_VEC_ENGINE -- requirements
Module: mult_vec_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 16: operand-pair buffer entries (power of 2, 2..256).
REQ-002 SHALL have parameter DATA_W, default 64: operand/product width (32 or 64); LANES = 512/DATA_W products per line.
REQ-003 SHALL have parameter MUL_LAT, default 2: multiplier pipeline stages (1..4).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- csr_wr_en  in  1  CSR write strobe.
- csr_wr_idx  in  2  CSR index.
- csr_wr_data  in  64  CSR write data.
- c1_alm_full  in  1  host write channel almost full.
- wr_valid  out  1  line write request.
- wr_addr  out  42  cache-line address (t_ccip_clAddr).
- wr_data  out  512  line payload.
- busy  out  1  engine not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  2  sticky: [0] buffer overflow, [1] write while busy.

Function
REQ-005 CSR map: idx0 base line address; idx1 operand A staging; idx2 operand B, which commits the (A,B) pair at the fill pointer; idx3 control: bit0 start, bit1 accumulate mode, bit2 signed, bit3 clear (count and err).
REQ-006 Operands SHALL be the low DATA_W bits of csr_wr_data.
REQ-007 Committing when count==DEPTH SHALL drop the pair and set err[0]; count is unchanged.
REQ-008 Any idx0..idx2 write while busy SHALL be ignored and set err[1]; an idx3 write while busy SHALL be ignored, and its start bit SHALL NOT queue.
REQ-009 States IDLE, ISSUE, DRAIN, WRITE, DONE; start in IDLE with count>0 -> ISSUE; start with count==0 -> DONE directly, no write.
REQ-010 ISSUE SHALL feed one pair per cycle into the multiplier, in commit order; after the last pair -> DRAIN; when the pipeline is empty and the last line is packed -> WRITE.
REQ-011 Product SHALL be the low DATA_W bits of A*B, signed or unsigned per control bit2 latched at start.
REQ-012 Element mode: product k SHALL occupy lane (k mod LANES) of line (k / LANES); unused lanes of the final line SHALL be zero.
REQ-013 Accumulate mode: a single DATA_W sum of all products, wrapping modulo 2^DATA_W, SHALL be written in lane 0 of one line, with other lanes zero.
REQ-014 Packed lines SHALL be held in a line buffer of ceil(DEPTH/LANES) entries; WRITE SHALL emit line j at wr_addr = base + j.
REQ-015 wr_valid SHALL be registered and high for exactly one cycle per line, only in cycles where c1_alm_full is low at the decision edge; while c1_alm_full is high, lines stall with no loss or reorder.
REQ-016 After the last line is issued -> DONE; DONE SHALL pulse done for one cycle, clear count to 0, and return to IDLE; the base address and err SHALL persist.
REQ-017 Latency with c1_alm_full low: first wr_valid SHALL occur no later than count + MUL_LAT + 3 cycles after the start write.
REQ-018 A pair committed in the same cycle as start SHALL NOT be included; start then sees the previous count.

Reset
REQ-019 Reset SHALL force state IDLE, wr_valid 0, done 0, busy 0, err 0, count 0, base address 0, and wr_data 0, and SHALL flush the multiplier pipeline.
REQ-020 Reset mid-operation SHALL abort with no further wr_valid pulses and no done pulse.

Structure
REQ-021 The state enum, CSR index constants, and control bit positions SHALL live in package mult_vec_pkg.
REQ-022 The multiplier SHALL be sub-module mult_vec_pipe (MUL_LAT stages, valid bit alongside data, signed select input).

Verification
REQ-023 DATA_W=64: base 0x1000, pairs (3,5),(7,-2 signed), start signed -> one line at 0x1000, lane0=15, lane1=-14 (0xFFFF_FFFF_FFFF_FFF2), other lanes 0, one done pulse.
REQ-024 Pairs k=1..10 of (k,k), element mode, c1_alm_full high for 20 cycles after start -> no wr_valid while full; then lines at base and base+1 holding 1,4,..,64 and 81,100, then done.
REQ-025 Accumulate mode, pairs (0xFFFF_FFFF_FFFF_FFFF,1),(2,1) unsigned -> single line with lane0 = 1 (wrap).
REQ-026 17 commits with DEPTH=16 -> err[0] set, 16 products written; start with count 0 -> done pulse, no wr_valid.
REQ-027 Reset asserted during WRITE of a 2-line job -> wr_valid low the next cycle, no done; new job afterwards completes correctly.
REQ-028 Operand writes while busy -> err[1] set, results unaffected.

Source files
------------

// File: rtl/mult_vec_pkg.sv
// Shared encodings for the vector multiply engine: FSM states, CSR indices
// and control-word bit positions.
package mult_vec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] CSR_BASE = 2'd0;
  localparam logic [1:0] CSR_OPA  = 2'd1;
  localparam logic [1:0] CSR_OPB  = 2'd2;
  localparam logic [1:0] CSR_CTRL = 2'd3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ACCUM  = 1;
  localparam int unsigned CTRL_SIGNED = 2;
  localparam int unsigned CTRL_CLEAR  = 3;

endpackage

// File: rtl/mult_vec_pipe.sv
// Pipelined DATA_W x DATA_W multiplier returning the low DATA_W product bits,
// with a valid bit carried alongside each stage.
module mult_vec_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [DATA_W-1:0] product
);

  logic [2*DATA_W-1:0] ext_a, ext_b;
  logic [DATA_W-1:0]   prod_lo;
  logic                vld_q [MUL_LAT];
  logic [DATA_W-1:0]   dat_q [MUL_LAT];

  always_comb begin
    ext_a   = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    ext_b   = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    prod_lo = DATA_W'(ext_a * ext_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= prod_lo;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[MUL_LAT-1];
  assign product   = dat_q[MUL_LAT-1];

endmodule

// File: rtl/mult_vec_engine.sv
// CSR-loaded operand-pair buffer, pipelined multiply, and packing of
// products (element or accumulate) into 512-bit lines written to the host.
module mult_vec_engine
  import mult_vec_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         csr_wr_en,
  input  logic [1:0]   csr_wr_idx,
  input  logic [63:0]  csr_wr_data,
  input  logic         c1_alm_full,
  output logic         wr_valid,
  output logic [41:0]  wr_addr,
  output logic [511:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err
);

  localparam int unsigned LANES  = 512 / DATA_W;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned NLINES = (DEPTH + LANES - 1) / LANES;
  localparam int unsigned LW     = (NLINES > 1) ? $clog2(NLINES) : 1;

  state_t            state;
  logic [CW-1:0]     count, issue_idx, pack_cnt, nlines, wr_idx;
  logic [41:0]       base;
  logic [DATA_W-1:0] opa, acc;
  logic              accum_q, signed_q;
  logic [DATA_W-1:0] a_buf [DEPTH];
  logic [DATA_W-1:0] b_buf [DEPTH];
  logic [511:0]      lines [NLINES];

  logic              idle, full, start_go, commit, drain_done;
  logic              pipe_out_valid;
  logic [DATA_W-1:0] pipe_product;

  always_comb begin
    idle       = (state == IDLE);
    full       = (count == CW'(DEPTH));
    start_go   = csr_wr_en && idle && (csr_wr_idx == CSR_CTRL) && csr_wr_data[CTRL_START];
    commit     = csr_wr_en && idle && (csr_wr_idx == CSR_OPB) && !full;
    drain_done = (state == DRAIN) && (pack_cnt == count);
  end

  assign busy = !idle;

  mult_vec_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state == ISSUE),
    .is_signed (signed_q),
    .a         (a_buf[issue_idx[AW-1:0]]),
    .b         (b_buf[issue_idx[AW-1:0]]),
    .out_valid (pipe_out_valid),
    .product   (pipe_product)
  );

  // Storage arrays carry no reset; the line buffer is zeroed at each accepted start.
  always_ff @(posedge clk) begin
    if (commit) begin
      a_buf[count[AW-1:0]] <= opa;
      b_buf[count[AW-1:0]] <= csr_wr_data[DATA_W-1:0];
    end
    if (start_go) begin
      for (int unsigned i = 0; i < NLINES; i++) lines[i] <= '0;
    end else if (pipe_out_valid && !accum_q) begin
      lines[LW'(int'(pack_cnt) / LANES)][(int'(pack_cnt) % LANES) * DATA_W +: DATA_W] <= pipe_product;
    end else if (drain_done && accum_q) begin
      lines[0] <= 512'(acc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      issue_idx <= '0;
      pack_cnt  <= '0;
      nlines    <= '0;
      wr_idx    <= '0;
      base      <= '0;
      opa       <= '0;
      acc       <= '0;
      accum_q   <= 1'b0;
      signed_q  <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= '0;
    end else begin
      wr_valid <= 1'b0;
      done     <= 1'b0;

      if (csr_wr_en) begin
        if (!idle) begin
          if (csr_wr_idx != CSR_CTRL) err[1] <= 1'b1;
        end else begin
          case (csr_wr_idx)
            CSR_BASE: base <= csr_wr_data[41:0];
            CSR_OPA:  opa  <= csr_wr_data[DATA_W-1:0];
            CSR_OPB:  if (full) err[0] <= 1'b1; else count <= count + 1'b1;
            default:  if (csr_wr_data[CTRL_CLEAR]) begin
                        count <= '0;
                        err   <= '0;
                      end
          endcase
        end
      end

      if (pipe_out_valid) begin
        pack_cnt <= pack_cnt + 1'b1;
        acc      <= acc + pipe_product;
      end

      case (state)
        IDLE: if (start_go) begin
          accum_q   <= csr_wr_data[CTRL_ACCUM];
          signed_q  <= csr_wr_data[CTRL_SIGNED];
          issue_idx <= '0;
          pack_cnt  <= '0;
          acc       <= '0;
          state     <= (count == '0) ? DONE : ISSUE;
        end
        ISSUE: begin
          issue_idx <= issue_idx + 1'b1;
          if (issue_idx == count - 1'b1) state <= DRAIN;
        end
        DRAIN: if (drain_done) begin
          nlines <= accum_q ? CW'(1) : CW'((int'(count) + LANES - 1) / LANES);
          wr_idx <= '0;
          state  <= WRITE;
        end
        WRITE: if (!c1_alm_full) begin
          wr_valid <= 1'b1;
          wr_addr  <= base + 42'(wr_idx);
          wr_data  <= lines[LW'(wr_idx)];
          wr_idx   <= wr_idx + 1'b1;
          if (wr_idx == nlines - 1'b1) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_vec_engine.sv
// Directed-vector bench for mult_vec_engine with default parameters
// (DEPTH=16, DATA_W=64, MUL_LAT=2, 8 lanes per line).
module tb_mult_vec_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         csr_wr_en;
  logic [1:0]   csr_wr_idx;
  logic [63:0]  csr_wr_data;
  logic         c1_alm_full;
  logic         wr_valid;
  logic [41:0]  wr_addr;
  logic [511:0] wr_data;
  logic         busy;
  logic         done;
  logic [1:0]   err;

  mult_vec_engine #(.DEPTH(16), .DATA_W(64), .MUL_LAT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_wr_en   (csr_wr_en),
    .csr_wr_idx  (csr_wr_idx),
    .csr_wr_data (csr_wr_data),
    .c1_alm_full (c1_alm_full),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int unsigned  n_vec = 0, n_err = 0;
  int unsigned  line_cnt = 0, done_cnt = 0, full_viol = 0;
  int unsigned  l0, d0, lat;
  logic [41:0]  cap_addr [64];
  logic [511:0] cap_data [64];
  logic [511:0] exp_line;

  // Capture every emitted line and done pulse just after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (wr_valid) begin
      if (line_cnt < 64) begin
        cap_addr[line_cnt] = wr_addr;
        cap_data[line_cnt] = wr_data;
      end
      if (c1_alm_full) full_viol++;
      line_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] idx, input logic [63:0] data);
    @(negedge clk);
    csr_wr_en   = 1'b1;
    csr_wr_idx  = idx;
    csr_wr_data = data;
    @(negedge clk);
    csr_wr_en   = 1'b0;
  endtask

  task automatic commit(input logic [63:0] a, input logic [63:0] b);
    csr_write(2'd1, a);
    csr_write(2'd2, b);
  endtask

  task automatic start(input logic [63:0] ctrl);
    l0 = line_cnt;
    d0 = done_cnt;
    csr_write(2'd3, ctrl);
  endtask

  task automatic wait_done(input int unsigned budget);
    lat = 0;
    for (int unsigned c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (lat == 0 && line_cnt != l0) lat = c;
      if (done_cnt != d0) return;
    end
  endtask

  task automatic check_line(input string tag, input int unsigned j,
                            input logic [41:0] a, input logic [511:0] d);
    check({tag, "_addr"}, cap_addr[l0 + j], a);
    check({tag, "_data"}, cap_data[l0 + j], d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    csr_wr_en = 1'b0;
    csr_wr_idx = '0;
    csr_wr_data = '0;
    c1_alm_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b0;

    // Signed element mode, two pairs, one line.
    csr_write(2'd0, 64'h1000);
    commit(64'd3, 64'd5);
    commit(64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    start(64'h5);
    check("t1_busy", busy, 1);
    wait_done(100);
    check("t1_latency", (lat >= 1 && lat <= 7), 1);
    check("t1_lines", line_cnt - l0, 1);
    check_line("t1_l0", 0, 42'h1000, {384'd0, 64'hFFFF_FFFF_FFFF_FFF2, 64'd15});
    @(negedge clk);
    check("t1_done", done_cnt - d0, 1);
    check("t1_idle", busy, 0);

    // Ten squares with host back-pressure for 20 cycles.
    for (int unsigned k = 1; k <= 10; k++) commit(64'(k), 64'(k));
    start(64'h1);
    c1_alm_full = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_stall", line_cnt - l0, 0);
    c1_alm_full = 1'b0;
    wait_done(100);
    check("t2_lines", line_cnt - l0, 2);
    check("t2_full_viol", full_viol, 0);
    exp_line = '0;
    for (int unsigned k = 1; k <= 8; k++) exp_line[(k-1)*64 +: 64] = 64'(k * k);
    check_line("t2_l0", 0, 42'h1000, exp_line);
    check_line("t2_l1", 1, 42'h1001, {384'd0, 64'd100, 64'd81});
    check("t2_done", done_cnt - d0, 1);

    // Unsigned accumulate with wrap.
    commit(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    commit(64'd2, 64'd1);
    start(64'h3);
    wait_done(100);
    check("t3_lines", line_cnt - l0, 1);
    check_line("t3_l0", 0, 42'h1000, 512'd1);

    // Overflow: 17 commits keep 16, then an empty start.
    for (int unsigned k = 0; k <= 16; k++) commit(64'(k), 64'd2);
    check("t4_err_ovf", err, 2'b01);
    start(64'h1);
    wait_done(100);
    check("t4_lines", line_cnt - l0, 2);
    exp_line = '0;
    for (int unsigned k = 0; k < 8; k++) exp_line[k*64 +: 64] = 64'(2 * k);
    check_line("t4_l0", 0, 42'h1000, exp_line);
    for (int unsigned k = 0; k < 8; k++) exp_line[k*64 +: 64] = 64'(2 * (k + 8));
    check_line("t4_l1", 1, 42'h1001, exp_line);
    start(64'h1);
    repeat (5) @(negedge clk);
    check("t4_empty_lines", line_cnt - l0, 0);
    check("t4_empty_done", done_cnt - d0, 1);
    csr_write(2'd3, 64'h8);
    check("t4_err_clear", err, 2'b00);

    // CSR writes while busy are dropped and flagged.
    commit(64'd4, 64'd4);
    commit(64'd5, 64'd5);
    commit(64'd6, 64'd6);
    start(64'h1);
    csr_write(2'd1, 64'd99);
    csr_write(2'd2, 64'd99);
    csr_write(2'd0, 64'h2000);
    wait_done(100);
    check("t5_err_busy", err, 2'b10);
    check("t5_lines", line_cnt - l0, 1);
    check_line("t5_l0", 0, 42'h1000, {320'd0, 64'd36, 64'd25, 64'd16});

    // Reset in the middle of a two-line WRITE.
    for (int unsigned k = 1; k <= 10; k++) commit(64'(k), 64'(k));
    start(64'h1);
    c1_alm_full = 1'b1;
    repeat (25) @(negedge clk);
    c1_alm_full = 1'b0;
    for (int unsigned c = 0; c < 10 && line_cnt == l0; c++) @(negedge clk);
    check("t6_first_line", line_cnt - l0, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_wr_valid", wr_valid, 0);
    repeat (5) @(negedge clk);
    check("t6_no_more_lines", line_cnt - l0, 1);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_rst_err", err, 0);
    reset = 1'b0;
    csr_write(2'd0, 64'h3000);
    commit(64'd9, 64'd9);
    start(64'h1);
    wait_done(100);
    check("t6_new_lines", line_cnt - l0, 1);
    check_line("t6_new_l0", 0, 42'h3000, 512'd81);
    check("t6_new_done", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
